// File: rtl/base12_pkg.sv
// Shared constants and FSM encoding for the base-12 digit serializer.
package base12_pkg;

  localparam int BASE        = 12;
  localparam int DIGIT_W     = 4;
  localparam int NDIGITS_MAX = 5;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/base12_divmod12.sv
// Combinational divide-by-12: restoring long division, one quotient bit per dividend bit.
module base12_divmod12
  import base12_pkg::*;
(
  input  logic [DATA_W-1:0]  dividend,
  output logic [DATA_W-1:0]  quotient,
  output logic [DIGIT_W-1:0] remainder
);

  // One spare bit: the partial remainder is at most 2*11+1 before subtraction.
  logic [DIGIT_W:0] r;

  always_comb begin
    r        = '0;
    quotient = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      r = {r[DIGIT_W-1:0], dividend[i]};
      if (r >= (DIGIT_W+1)'(BASE)) begin
        r           = r - (DIGIT_W+1)'(BASE);
        quotient[i] = 1'b1;
      end
    end
    remainder = r[DIGIT_W-1:0];
  end

endmodule

// File: rtl/base12_digit_serializer.sv
// Buffers 16-bit ALU results and converts each to NDIGITS base-12 digits,
// one digit per cycle, presenting the result under a valid/ready handshake.
module base12_digit_serializer
  import base12_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int NDIGITS    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic [DIGIT_W*NDIGITS-1:0] out_digits,
  output logic [2:0]                 out_ndigits,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_mem;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [CNT_W-1:0]                  fifo_cnt;
  logic                              fifo_empty;
  logic                              fifo_full;
  logic                              push;
  logic                              pop;
  logic                              drop;

  state_e                     state, state_nxt;
  logic [DATA_W-1:0]          work, work_nxt;
  logic [2:0]                 k, k_nxt;
  logic [DIGIT_W*NDIGITS-1:0] digits_nxt;
  logic [2:0]                 ndig_nxt;
  logic [DATA_W-1:0]          quo;
  logic [DIGIT_W-1:0]         rem;

  // ---------------- input FIFO ----------------
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot the write lands in, so full+pop still accepts.
  assign push       = in_valid && (!fifo_full || pop);
  assign drop       = in_valid && fifo_full && !pop;
  assign wr_ptr     = rd_ptr + fifo_cnt[PTR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clear_ovf)
      overflow <= 1'b0;
  end

  // ---------------- conversion datapath ----------------
  base12_divmod12 u_divmod (
    .dividend  (work),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    k_nxt      = k;
    digits_nxt = out_digits;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          work_nxt  = fifo_mem[rd_ptr];
          k_nxt     = '0;
          state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        for (int i = 0; i < NDIGITS; i++)
          if (k == 3'(i))
            digits_nxt[DIGIT_W*i +: DIGIT_W] = rem;
        work_nxt = quo;
        k_nxt    = k + 3'd1;
        if (k == 3'(NDIGITS - 1))
          state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Highest non-zero digit decides the significant count; zero still reports one digit.
  always_comb begin
    ndig_nxt = 3'd1;
    for (int i = 1; i < NDIGITS; i++)
      if (digits_nxt[DIGIT_W*i +: DIGIT_W] != '0)
        ndig_nxt = 3'(i + 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      work        <= '0;
      k           <= '0;
      out_digits  <= '0;
      out_ndigits <= 3'd1;
    end else begin
      state      <= state_nxt;
      work       <= work_nxt;
      k          <= k_nxt;
      out_digits <= digits_nxt;
      if (state == ST_CONVERT && state_nxt == ST_HOLD)
        out_ndigits <= ndig_nxt;
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign busy      = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_base12_digit_serializer.sv
// Randomized and directed checks of the base-12 serializer against an arithmetic reference.
module tb_base12_digit_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [19:0] out_digits;
  logic [2:0]  out_ndigits;
  logic        out_valid;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  base12_digit_serializer #(.FIFO_DEPTH(2), .NDIGITS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_digits  (out_digits),
    .out_ndigits (out_ndigits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  // Reference: repeated division gives the digits; significant count is how many
  // times the value can be divided by 12 before reaching zero.
  function automatic logic [19:0] ref_digits(input int v);
    logic [19:0] d;
    d = '0;
    for (int i = 0; i < 5; i++) begin
      d[4*i +: 4] = 4'(v % 12);
      v = v / 12;
    end
    return d;
  endfunction

  function automatic logic [2:0] ref_nd(input int v);
    int n;
    n = 1;
    v = v / 12;
    while (v > 0) begin
      n++;
      v = v / 12;
    end
    return 3'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    if (out_digits !== 20'h0) begin n_bad++; $display("FAIL reset_digits: got %h expected 00000", out_digits); end
    if (out_ndigits !== 3'd1) begin n_bad++; $display("FAIL reset_nd: got %0d expected 1", out_ndigits); end
    reset = 1'b0;
    tick();
  endtask

  // One value through an idle block with the consumer ready.
  task automatic test_single(input logic [15:0] v, input logic [19:0] exp_d, input logic [2:0] exp_n);
    int n;
    out_ready = 1'b1;
    in_data   = v;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_valid(n);
    n_cmp += 6;
    if (n != 6) begin n_bad++; $display("FAIL latency(%0d): got %0d expected 6", v, n); end
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL valid(%0d): got %b expected 1", v, out_valid); end
    if (out_digits !== exp_d) begin n_bad++; $display("FAIL digits(%0d): got %h expected %h", v, out_digits, exp_d); end
    if (out_ndigits !== exp_n) begin n_bad++; $display("FAIL ndigits(%0d): got %0d expected %0d", v, out_ndigits, exp_n); end
    tick();
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL valid_drop(%0d): got %b expected 0", v, out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy(%0d): got %b expected 0", v, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    test_single(16'd0,     20'h00000, 3'd1);
    test_single(16'd65535, 20'h31B13, 3'd5);
    test_single(16'd144,   20'h00100, 3'd3);
    test_single(16'd11,    20'h0000B, 3'd1);
  endtask

  task automatic test_random();
    int n;
    int v;
    int h;
    logic [19:0] held;
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 4) == 0 ? 65535 : (12 ** $urandom_range(0, 4)) - $urandom_range(0, 1);
        default: v = $urandom_range(0, 65535);
      endcase
      out_ready = 1'b0;
      in_data   = 16'(v);
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      wait_valid(n);
      n_cmp += 4;
      if (n != 6) begin n_bad++; $display("FAIL rnd_latency(%0d): got %0d expected 6", v, n); end
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_valid(%0d): got %b expected 1", v, out_valid); end
      if (out_digits !== ref_digits(v)) begin n_bad++; $display("FAIL rnd_digits(%0d): got %h expected %h", v, out_digits, ref_digits(v)); end
      if (out_ndigits !== ref_nd(v)) begin n_bad++; $display("FAIL rnd_nd(%0d): got %0d expected %0d", v, out_ndigits, ref_nd(v)); end
      held = out_digits;
      h = $urandom_range(0, 3);
      for (int c = 0; c < h; c++) begin
        tick();
        n_cmp += 2;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid(%0d): got %b expected 1", v, out_valid); end
        if (out_digits !== held) begin n_bad++; $display("FAIL hold_stable(%0d): got %h expected %h", v, out_digits, held); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drop(%0d): got %b expected 0", v, out_valid); end
    end
  endtask

  // Four back-to-back words with the consumer stalled; optionally clear on the dropping edge.
  task automatic test_overflow(input bit clear_on_drop);
    int n;
    logic [15:0] q[$];
    logic [19:0] held;
    q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data   = 16'($urandom_range(0, 65535));
      in_valid  = 1'b1;
      clear_ovf = clear_on_drop && (i == 3);
      if (i < 3) q.push_back(in_data);
      tick();
      n_cmp++;
      if (overflow !== (i == 3)) begin n_bad++; $display("FAIL ovf_step%0d: got %b expected %b", i, overflow, i == 3); end
    end
    in_valid  = 1'b0;
    clear_ovf = 1'b0;
    wait_valid(n);
    held = out_digits;
    repeat (3) tick();
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
    if (out_digits !== held) begin n_bad++; $display("FAIL stall_stable: got %h expected %h", out_digits, held); end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_valid(n);
      n_cmp += 3;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid%0d: got %b expected 1", j, out_valid); end
      if (out_digits !== ref_digits(q[j])) begin n_bad++; $display("FAIL drain_digits%0d: got %h expected %h", j, out_digits, ref_digits(q[j])); end
      if (out_ndigits !== ref_nd(q[j])) begin n_bad++; $display("FAIL drain_nd%0d: got %0d expected %0d", j, out_ndigits, ref_nd(q[j])); end
      tick();
    end
    repeat (3) tick();
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL drain_busy: got %b expected 0", busy); end
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    out_ready = 1'b0;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] q[$];
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data  = 16'($urandom_range(0, 65535));
      in_valid = 1'b1;
      q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    wait_valid(n);
    for (int j = 0; j < 3; j++) begin
      n_cmp += 2;
      if (out_digits !== ref_digits(q[j])) begin n_bad++; $display("FAIL b2b_digits%0d: got %h expected %h", j, out_digits, ref_digits(q[j])); end
      if (out_ndigits !== ref_nd(q[j])) begin n_bad++; $display("FAIL b2b_nd%0d: got %0d expected %0d", j, out_ndigits, ref_nd(q[j])); end
      tick();
      if (j < 2) begin
        wait_valid(n);
        n_cmp++;
        if (n + 1 != 7) begin n_bad++; $display("FAIL b2b_period%0d: got %0d expected 7", j, n + 1); end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    in_data   = 16'd1234;
    in_valid  = 1'b1;
    tick();
    in_data   = 16'd4321;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    if (out_digits !== 20'h0) begin n_bad++; $display("FAIL mid_digits: got %h expected 00000", out_digits); end
    if (out_ndigits !== 3'd1) begin n_bad++; $display("FAIL mid_nd: got %0d expected 1", out_ndigits); end
    tick();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL mid_residue: got %0d active cycles expected 0", seen); end
    test_single(16'd12, 20'h00010, 3'd2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
